cmap_znz_decoder: RTL and testbench

//  Zero/non-zero (ZNZ) bitmap decompressor. Per beat it takes a ZNZ bitmap for NUM_GROUP

---
 rtl/cmap_znz_decoder.sv | 123 ++++++++++++
 tb/tb_cmap_znz_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmap_znz_decoder.sv
// ZNZ bitmap decompressor: scatters packed non-zero bytes back to their bitmap
// positions to rebuild a dense tile, with a single registered output stage.

// Per-group scatter: each position looks up its byte in the packed stream at
// base + (number of set bits below it); unset positions produce zero.
module cmap_znz_group #(
  parameter int ZNZ_BITS  = 16,
  parameter int DATA_W    = 8,
  parameter int DIN_BYTES = 64,
  parameter int BW        = 8
) (
  input  logic [ZNZ_BITS-1:0]         bits,
  input  logic [BW-1:0]               base,
  input  logic [BW-1:0]               limit,
  input  logic [DIN_BYTES*DATA_W-1:0] enc,
  output logic [ZNZ_BITS*DATA_W-1:0]  dout
);
  localparam logic [BW-1:0] DIN_LIM = BW'(DIN_BYTES);

  logic [BW-1:0] cnt;
  logic [BW-1:0] idx;

  // LSB-first scan; bytes beyond the declared count or the stream are never read
  always_comb begin
    dout = '0;
    cnt  = '0;
    idx  = '0;
    for (int i = 0; i < ZNZ_BITS; i++) begin
      idx = base + cnt;
      if (bits[i] && (idx < limit) && (idx < DIN_LIM))
        dout[i*DATA_W +: DATA_W] = enc[idx*DATA_W +: DATA_W];
      cnt = cnt + {{(BW-1){1'b0}}, bits[i]};
    end
  end
endmodule

module cmap_znz_decoder #(
  parameter int CFG_M     = 8,
  parameter int CFG_N     = 8,
  parameter int ZNZ_BITS  = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_GROUP = 4,
  parameter int DIN_BYTES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_GROUP*ZNZ_BITS-1:0] znz_din,
  input  logic                          znz_vld,
  output logic                          znz_rdy,
  input  logic [NUM_GROUP*($clog2(ZNZ_BITS)+1)-1:0] nz_num,
  output logic                          nz_rdy,
  input  logic [DIN_BYTES*DATA_W-1:0]   enc_din,
  input  logic                          enc_vld,
  output logic                          enc_rdy,
  output logic [DIN_BYTES*DATA_W-1:0]   dec_dout,
  output logic                          dec_vld,
  input  logic                          dec_rdy
);
  localparam int CW = $clog2(ZNZ_BITS) + 1;
  // Extra headroom so a bogus count vector cannot wrap the prefix sum
  localparam int BW = $clog2(DIN_BYTES) + 2;

  generate
    if (CFG_M * CFG_N < DIN_BYTES || ZNZ_BITS * NUM_GROUP != DIN_BYTES) begin : g_bad_cfg
      $error("cmap_znz_decoder: inconsistent tile geometry");
    end
  endgenerate

  logic                                        out_free;
  logic                                        fire;
  logic [NUM_GROUP-1:0][BW-1:0]                base;
  logic [BW-1:0]                               total;
  logic [BW-1:0]                               acc;
  logic [NUM_GROUP-1:0][ZNZ_BITS*DATA_W-1:0]   tile;

  assign out_free = !dec_vld || dec_rdy;
  assign znz_rdy  = !rst && enable && out_free && enc_vld;
  assign nz_rdy   = znz_rdy;
  assign enc_rdy  = !rst && enable && out_free && znz_vld;
  assign fire     = !rst && enable && out_free && znz_vld && enc_vld;

  // Exclusive prefix sum of the trusted per-group counts gives each group's base
  always_comb begin
    acc  = '0;
    base = '0;
    for (int g = 0; g < NUM_GROUP; g++) begin
      base[g] = acc;
      acc     = acc + BW'(nz_num[g*CW +: CW]);
    end
    total = acc;
  end

  generate
    for (genvar g = 0; g < NUM_GROUP; g++) begin : g_grp
      cmap_znz_group #(
        .ZNZ_BITS (ZNZ_BITS),
        .DATA_W   (DATA_W),
        .DIN_BYTES(DIN_BYTES),
        .BW       (BW)
      ) u_grp (
        .bits (znz_din[g*ZNZ_BITS +: ZNZ_BITS]),
        .base (base[g]),
        .limit(total),
        .enc  (enc_din),
        .dout (tile[g])
      );
    end
  endgenerate

  // Output register: load on fire, hold under backpressure, drop valid on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_vld  <= 1'b0;
      dec_dout <= '0;
    end else if (fire) begin
      dec_vld  <= 1'b1;
      dec_dout <= tile;
    end else if (dec_rdy) begin
      dec_vld  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cmap_znz_decoder.sv
// Directed bench for cmap_znz_decoder with an expected-tile scoreboard.
module tb_cmap_znz_decoder;
  localparam int ZB = 16, DW = 8, NG = 4, DB = 64, CW = 5;
  localparam int TW = DB * DW;

  logic            clk = 1'b0;
  logic            rst, enable;
  logic [NG*ZB-1:0] znz_din;
  logic            znz_vld, znz_rdy, nz_rdy;
  logic [NG*CW-1:0] nz_num;
  logic [TW-1:0]   enc_din, dec_dout;
  logic            enc_vld, enc_rdy, dec_vld, dec_rdy;

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int popped = 0;
  logic [TW-1:0] q[$];
  bit zero_exp = 0;

  always #5 clk = ~clk;

  cmap_znz_decoder dut (
    .clk(clk), .rst(rst), .enable(enable),
    .znz_din(znz_din), .znz_vld(znz_vld), .znz_rdy(znz_rdy),
    .nz_num(nz_num), .nz_rdy(nz_rdy),
    .enc_din(enc_din), .enc_vld(enc_vld), .enc_rdy(enc_rdy),
    .dec_dout(dec_dout), .dec_vld(dec_vld), .dec_rdy(dec_rdy)
  );

  // Reference scatter: walk the whole bitmap with one running stream pointer
  function automatic logic [TW-1:0] model(input logic [NG*ZB-1:0] z, input logic [TW-1:0] e);
    logic [TW-1:0] t;
    int k;
    t = '0;
    k = 0;
    for (int j = 0; j < NG*ZB; j++)
      if (z[j]) begin
        t[j*DW +: DW] = e[k*DW +: DW];
        k++;
      end
    return t;
  endfunction

  task automatic chk1(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input logic [TW-1:0] o, input logic [TW-1:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One cycle: check outputs at negedge, update scoreboard, advance past posedge
  task automatic step(output bit fired);
    bit ev, of;
    @(negedge clk);
    ev = (q.size() != 0);
    chk1("dec_vld", dec_vld, ev);
    if (ev) chkw("dec_dout", dec_dout, q[0]);
    else if (zero_exp) chkw("dec_dout_zero", dec_dout, '0);
    of = !ev || dec_rdy;
    fired = !rst && enable && of && znz_vld && enc_vld;
    chk1("znz_rdy", znz_rdy, !rst && enable && of && enc_vld);
    chk1("nz_rdy", nz_rdy, !rst && enable && of && enc_vld);
    chk1("enc_rdy", enc_rdy, !rst && enable && of && znz_vld);
    if (rst) begin
      q.delete();
      zero_exp = 1;
    end else begin
      if (ev && dec_rdy) begin
        void'(q.pop_front());
        popped++;
      end
      if (fired) begin
        q.push_back(model(znz_din, enc_din));
        pushed++;
        zero_exp = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NG*ZB-1:0] z, input logic [TW-1:0] e, input logic vz, input logic ve);
    znz_din = z;
    enc_din = e;
    for (int g = 0; g < NG; g++) nz_num[g*CW +: CW] = CW'($countones(z[g*ZB +: ZB]));
    znz_vld = vz;
    enc_vld = ve;
  endtask

  task automatic idle_steps(input int n);
    bit f;
    for (int i = 0; i < n; i++) step(f);
  endtask

  // Present one beat until the bench predicts it is consumed
  task automatic send(input logic [NG*ZB-1:0] z, input logic [TW-1:0] e);
    bit f;
    f = 0;
    drive(z, e, 1'b1, 1'b1);
    for (int t = 0; t < 50 && !f; t++) step(f);
    chk1("send_timeout", f, 1'b1);
    znz_vld = 1'b0;
    enc_vld = 1'b0;
  endtask

  function automatic logic [TW-1:0] rnd_enc();
    logic [TW-1:0] e;
    for (int i = 0; i < TW/32; i++) e[i*32 +: 32] = $urandom;
    return e;
  endfunction

  function automatic logic [NG*ZB-1:0] rnd_z();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [TW-1:0] e;
    logic [NG*ZB-1:0] z;
    logic [TW-1:0] exp_t;
    bit f;

    rst = 1'b1; enable = 1'b1; dec_rdy = 1'b1;
    drive('0, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle_steps(2);
    rst = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    idle_steps(1);

    // All-dense: byte k = k, element j must equal j
    for (int k = 0; k < DB; k++) e[k*DW +: DW] = DW'(k);
    exp_t = e;
    send('1, e);
    chkw("dense_direct", q[0], exp_t);
    idle_steps(2);

    // All-zero bitmap with arbitrary stream
    send('0, rnd_enc());
    idle_steps(2);

    // Sparse: g0=8001, g2=0010 -> elem0=AA, elem15=BB, elem36=CC
    e = '0;
    e[7:0] = 8'hAA; e[15:8] = 8'hBB; e[23:16] = 8'hCC; e[31:24] = 8'hDD;
    z = 64'h0000_0010_0000_8001;
    exp_t = '0;
    exp_t[0*DW +: DW] = 8'hAA; exp_t[15*DW +: DW] = 8'hBB; exp_t[36*DW +: DW] = 8'hCC;
    send(z, e);
    chkw("sparse_direct", q[0], exp_t);
    idle_steps(2);

    // Backpressure: hold one beat for 5 cycles, then stream back-to-back
    dec_rdy = 1'b0;
    drive(rnd_z(), rnd_enc(), 1'b1, 1'b1);
    step(f);
    znz_vld = 1'b0; enc_vld = 1'b0;
    drive(rnd_z(), rnd_enc(), 1'b1, 1'b1);
    idle_steps(5);
    dec_rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      step(f);
      chk1("stream_fire", f, 1'b1);
      drive(rnd_z(), rnd_enc(), 1'b1, 1'b1);
    end
    drive('0, '0, 1'b0, 1'b0);
    idle_steps(3);

    // Skewed valids: bitmap early, stream 3 cycles later
    drive(rnd_z(), rnd_enc(), 1'b1, 1'b0);
    idle_steps(3);
    enc_vld = 1'b1;
    step(f);
    chk1("skew_fire", f, 1'b1);
    drive('0, '0, 1'b0, 1'b0);
    idle_steps(3);

    // enable=0: pending output drains, no new fire
    dec_rdy = 1'b0;
    send(rnd_z(), rnd_enc());
    idle_steps(2);
    enable = 1'b0;
    drive(rnd_z(), rnd_enc(), 1'b1, 1'b1);
    dec_rdy = 1'b1;
    idle_steps(3);
    enable = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    idle_steps(1);

    // Reset with pending output
    dec_rdy = 1'b0;
    send(64'hFFFF_0000_00FF_1234, rnd_enc());
    idle_steps(1);
    rst = 1'b1;
    idle_steps(1);
    rst = 1'b0;
    dec_rdy = 1'b1;
    idle_steps(2);

    tests++;
    assert (q.size() == 0 && popped > 0) else begin
      fails++;
      $error("FAIL scoreboard_end observed=%0d pending expected=0 (pushed=%0d popped=%0d)", q.size(), pushed, popped);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
